// File: rtl/pc_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
// Shared definitions for the fetch-stage controller:
//   - fetch_state_e    : instruction-SRAM handshake states
//   - RESET_PC_DEFAULT : first fetch address after reset (MIPS boot vector)
//   - seq_pc()         : sequential next PC, wraps modulo 2^32
// ----------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    // S_REQ  : request presented on inst_req/inst_addr, waiting for addr_ok
    // S_WAIT : request accepted, waiting for data_ok
    // S_HAVE : data returned while D was stalled; held in the fetch buffer
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if_id_reg.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl_if_id_reg
// IF/ID pipeline register with load and clear controls.
//   clk, resetn       : clock, asynchronous active-low reset
//   load_i            : capture instr_i/pc_i/ds_i and mark the entry valid
//   clear_i           : insert a bubble (valid and delay-slot flag cleared,
//                       instruction/PC fields keep their old values)
//   instr_i, pc_i     : instruction word and its address from fetch
//   ds_i              : the loaded instruction sits in a branch delay slot
//   instr_o, pc_o     : registered instruction and PC
//   valid_o, ds_o     : registered valid and delay-slot flag
// Neither load nor clear asserted means hold (stall).
// ----------------------------------------------------------------------------
module pc_fetch_ctrl_if_id_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        ds_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        ds_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        ds_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
            ds_q    <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
            ds_q    <= ds_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ds_q    <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;
    assign ds_o    = ds_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch-stage controller of the 5-stage MIPS pipeline: owns the fetch PC,
// the instruction-SRAM request handshake and the IF/ID register. Branch and
// jump redirects from D take effect after the delay slot; an exception/eret
// pulse flushes fetch and restarts at except_pc.
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   stall_d                      : hold IF/ID contents
//   branch_d, taken_d            : conditional branch in D and its outcome
//   branch_target_d              : branch target of the instruction in D
//   jump_d, jump_target_d        : j/jal/jr/jalr in D and its target
//   except_valid, except_pc      : one-cycle redirect pulse and address
//   inst_req, inst_addr          : SRAM request and address (= pc_f)
//   inst_addr_ok, inst_data_ok   : SRAM request accepted / data valid
//   inst_rdata                   : SRAM read data
//   fetch_busy                   : F has no instruction ready
//   instr_d, pc_d, valid_d       : IF/ID contents
//   in_delayslot_d               : instr_d is a delay-slot instruction
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_d,
    input  logic        branch_d,
    input  logic        taken_d,
    input  logic [31:0] branch_target_d,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    input  logic        except_valid,
    input  logic [31:0] except_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fetch_busy,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        in_delayslot_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  redir_target_q, redir_target_d;
    logic         redir_valid_q, redir_valid_d;
    logic         ds_pending_q, ds_pending_d;
    logic         discard_q, discard_d;

    logic         ready;
    logic         adv;
    logic         ctrl_flow_d;
    logic         redirect_now;
    logic         ds_flag;
    logic         if_id_clear;
    logic [31:0]  tgt;
    logic [31:0]  next_pc;
    logic [31:0]  fetch_data;

    // ------------------------------------------------------------------
    // Handshake status
    // ------------------------------------------------------------------
    assign ready = ((state_q == S_WAIT) & inst_data_ok & ~discard_q)
                 | (state_q == S_HAVE);
    assign adv        = ready & ~stall_d & ~except_valid;
    assign fetch_busy = ~ready;
    assign inst_req   = (state_q == S_REQ);
    assign inst_addr  = pc_f_q;

    // Straight from the SRAM when it returns this cycle, else the buffer.
    assign fetch_data = (state_q == S_HAVE) ? buf_q : inst_rdata;

    // ------------------------------------------------------------------
    // Redirect and delay-slot tracking
    // ------------------------------------------------------------------
    assign ctrl_flow_d  = branch_d | jump_d;
    assign redirect_now = valid_d & ~stall_d & ((branch_d & taken_d) | jump_d);
    assign tgt          = jump_d ? jump_target_d : branch_target_d;

    // A saved redirect always wins: it belongs to an older branch whose
    // delay slot is the instruction being advanced now.
    assign next_pc = redir_valid_q ? redir_target_q
                   : redirect_now  ? tgt
                   : seq_pc(pc_f_q);

    // The instruction entering D is a delay slot if a branch/jump left D
    // earlier without an advance, or is leaving D in this very cycle.
    assign ds_flag = ds_pending_q | (valid_d & ctrl_flow_d);

    // Exception flushes D even under stall; otherwise an unstalled D with
    // nothing to take in becomes a bubble.
    assign if_id_clear = except_valid | (~stall_d & ~adv);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        buf_d     = buf_q;
        if (except_valid) begin
            case (state_q)
                S_REQ: begin
                    // An accepted request still owes a response; drop it.
                    if (inst_addr_ok) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (inst_addr_ok) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (adv) begin
                            state_d = S_REQ;
                        end else begin
                            buf_d   = inst_rdata;
                            state_d = S_HAVE;
                        end
                    end
                end
                S_HAVE: begin
                    if (adv) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC, pending redirect and delay-slot next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_f_d         = pc_f_q;
        redir_valid_d  = redir_valid_q;
        redir_target_d = redir_target_q;
        ds_pending_d   = ds_pending_q;
        if (except_valid) begin
            pc_f_d        = except_pc;
            redir_valid_d = 1'b0;
            ds_pending_d  = 1'b0;
        end else if (adv) begin
            pc_f_d        = next_pc;
            redir_valid_d = 1'b0;
            ds_pending_d  = 1'b0;
        end else begin
            // Branch leaves D before its delay slot is ready: remember both
            // the redirect and that the next instruction is a delay slot.
            if (redirect_now) begin
                redir_valid_d  = 1'b1;
                redir_target_d = tgt;
            end
            if (valid_d & ctrl_flow_d & ~stall_d) begin
                ds_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_REQ;
            pc_f_q         <= RESET_PC;
            buf_q          <= 32'd0;
            redir_target_q <= 32'd0;
            redir_valid_q  <= 1'b0;
            ds_pending_q   <= 1'b0;
            discard_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_f_q         <= pc_f_d;
            buf_q          <= buf_d;
            redir_target_q <= redir_target_d;
            redir_valid_q  <= redir_valid_d;
            ds_pending_q   <= ds_pending_d;
            discard_q      <= discard_d;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    pc_fetch_ctrl_if_id_reg u_if_id (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (adv),
        .clear_i (if_id_clear),
        .instr_i (fetch_data),
        .pc_i    (pc_f_q),
        .ds_i    (ds_flag),
        .instr_o (instr_d),
        .pc_o    (pc_d),
        .valid_o (valid_d),
        .ds_o    (in_delayslot_d)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Scoreboard bench for pc_fetch_ctrl. Each test pushes the expected SRAM
// request addresses and the expected IF/ID transactions; an SRAM responder
// checks every accepted address and a D-stage monitor checks every
// instruction as it leaves D (valid_d & ~stall_d).
// ----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall_d = 1'b0;
    logic        branch_d, taken_d, jump_d;
    logic [31:0] branch_target_d, jump_target_d;
    logic        except_valid = 1'b0;
    logic [31:0] except_pc = 32'd0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        fetch_busy;
    logic [31:0] instr_d, pc_d;
    logic        valid_d, in_delayslot_d;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ds;
    } d_exp_t;

    d_exp_t      exp_d_q[$];
    logic [31:0] exp_addr_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 0;

    // decode-stage stand-in: one control-flow instruction per test
    logic        br_en = 1'b0;
    logic        br_is_jump = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'd0;
    logic [31:0] br_tgt = 32'd0;

    logic chk_rate = 1'b0;
    logic have_prev = 1'b0;
    int   prev_cyc = 0;

    assign branch_d        = br_en && valid_d && (pc_d == br_pc) && !br_is_jump;
    assign jump_d          = br_en && valid_d && (pc_d == br_pc) && br_is_jump;
    assign taken_d         = br_taken;
    assign branch_target_d = br_is_jump ? 32'hDEAD_0000 : br_tgt;
    assign jump_target_d   = br_is_jump ? br_tgt : 32'hBAD0_0000;

    pc_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall_d         (stall_d),
        .branch_d        (branch_d),
        .taken_d         (taken_d),
        .branch_target_d (branch_target_d),
        .jump_d          (jump_d),
        .jump_target_d   (jump_target_d),
        .except_valid    (except_valid),
        .except_pc       (except_pc),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .fetch_busy      (fetch_busy),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .valid_d         (valid_d),
        .in_delayslot_d  (in_delayslot_d)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_addr(input logic [31:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic exp_d(input logic [31:0] pc, input logic ds);
        d_exp_t e;
        e.pc = pc;
        e.instr = instr_of(pc);
        e.ds = ds;
        exp_d_q.push_back(e);
    endtask

    // SRAM responder: accepts a request in the cycle it is presented, returns
    // data lat+1 cycles later; stops accepting once the expected list is used up.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          cnt;
        logic [31:0] ea;
        pend = 1'b0;
        pend_addr = 32'd0;
        cnt = 0;
        forever begin
            @(negedge clk);
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = instr_of(pend_addr);
                        pend         = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (!pend && !inst_data_ok && inst_req && exp_addr_q.size() > 0) begin
                    inst_addr_ok = 1'b1;
                    pend      = 1'b1;
                    pend_addr = inst_addr;
                    cnt       = lat;
                    ea = exp_addr_q.pop_front();
                    $display("REQ addr=%h", inst_addr);
                    check("inst_addr", inst_addr, ea);
                end
            end
        end
    end

    // D-stage monitor: each instruction leaves D in exactly one cycle
    initial forever begin
        d_exp_t e;
        @(negedge clk);
        #2;
        if (resetn && valid_d && !stall_d) begin
            $display("D pc=%h instr=%h ds=%0d", pc_d, instr_d, in_delayslot_d);
            if (exp_d_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d_stray actual pc_d=%h required no instruction", pc_d);
            end else begin
                e = exp_d_q.pop_front();
                check("pc_d", pc_d, e.pc);
                check("instr_d", instr_d, e.instr);
                check("in_delayslot_d", {31'd0, in_delayslot_d}, {31'd0, e.ds});
            end
            if (chk_rate && have_prev) check("issue_rate", cyc - prev_cyc, 2);
            have_prev = 1'b1;
            prev_cyc = cyc;
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        stall_d = 1'b0;
        except_valid = 1'b0;
        br_en = 1'b0;
        br_is_jump = 1'b0;
        br_taken = 1'b0;
        chk_rate = 1'b0;
        have_prev = 1'b0;
        exp_d_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_inst_req", {31'd0, inst_req}, 32'd1);
        check("rst_inst_addr", inst_addr, 32'hBFC0_0000);
        check("rst_valid_d", {31'd0, valid_d}, 32'd0);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_instr_d", instr_d, 32'd0);
        check("rst_in_ds", {31'd0, in_delayslot_d}, 32'd0);
        check("rst_fetch_busy", {31'd0, fetch_busy}, 32'd1);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_d_q.size() == 0 && exp_addr_q.size() == 0) break;
        end
        repeat (8) @(negedge clk);
        $display("TEST %s done", name);
        check("drain_d", exp_d_q.size(), 0);
        check("drain_addr", exp_addr_q.size(), 0);
    endtask

    initial begin
        int found;

        // 1: sequential fetch, single-cycle SRAM, one instruction per 2 cycles
        do_reset();
        lat = 0;
        chk_rate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr(32'hBFC0_0000 + 32'(4 * i));
            exp_d(32'hBFC0_0000 + 32'(4 * i), 1'b0);
        end
        drain("seq");

        // 2: taken beq at BFC00010 -> BFC00100, delay slot returns promptly
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            lat = (pass == 0) ? 0 : 3;
            br_en = 1'b1; br_is_jump = 1'b0; br_taken = 1'b1;
            br_pc = 32'hBFC0_0010; br_tgt = 32'hBFC0_0100;
            for (int i = 0; i < 6; i++) exp_addr(32'hBFC0_0000 + 32'(4 * i));
            exp_addr(32'hBFC0_0100);
            exp_addr(32'hBFC0_0104);
            for (int i = 0; i < 5; i++) exp_d(32'hBFC0_0000 + 32'(4 * i), 1'b0);
            exp_d(32'hBFC0_0014, 1'b1);
            exp_d(32'hBFC0_0100, 1'b0);
            exp_d(32'hBFC0_0104, 1'b0);
            drain(pass == 0 ? "beq_taken" : "beq_taken_late");
        end

        // 3: not-taken bne at BFC00008: delay slot flagged, fetch stays sequential
        do_reset();
        lat = 0;
        br_en = 1'b1; br_is_jump = 1'b0; br_taken = 1'b0;
        br_pc = 32'hBFC0_0008; br_tgt = 32'hBFC0_0400;
        for (int i = 0; i < 6; i++) exp_addr(32'hBFC0_0000 + 32'(4 * i));
        exp_d(32'hBFC0_0000, 1'b0);
        exp_d(32'hBFC0_0004, 1'b0);
        exp_d(32'hBFC0_0008, 1'b0);
        exp_d(32'hBFC0_000C, 1'b1);
        exp_d(32'hBFC0_0010, 1'b0);
        exp_d(32'hBFC0_0014, 1'b0);
        drain("bne_not_taken");

        // 4: jump to FFFFFFFC, sequential fetch wraps to 00000000
        do_reset();
        lat = 1;
        br_en = 1'b1; br_is_jump = 1'b1; br_taken = 1'b0;
        br_pc = 32'hBFC0_0004; br_tgt = 32'hFFFF_FFFC;
        exp_addr(32'hBFC0_0000); exp_addr(32'hBFC0_0004); exp_addr(32'hBFC0_0008);
        exp_addr(32'hFFFF_FFFC); exp_addr(32'h0000_0000); exp_addr(32'h0000_0004);
        exp_d(32'hBFC0_0000, 1'b0);
        exp_d(32'hBFC0_0004, 1'b0);
        exp_d(32'hBFC0_0008, 1'b1);
        exp_d(32'hFFFF_FFFC, 1'b0);
        exp_d(32'h0000_0000, 1'b0);
        exp_d(32'h0000_0004, 1'b0);
        drain("jump_wrap");

        // 5: exception while waiting for BFC00008 data -> data dropped, refetch at BFC00380
        do_reset();
        lat = 3;
        except_pc = 32'hBFC0_0380;
        exp_addr(32'hBFC0_0000); exp_addr(32'hBFC0_0004); exp_addr(32'hBFC0_0008);
        exp_addr(32'hBFC0_0380); exp_addr(32'hBFC0_0384);
        exp_d(32'hBFC0_0000, 1'b0);
        exp_d(32'hBFC0_0004, 1'b0);
        exp_d(32'hBFC0_0380, 1'b0);
        exp_d(32'hBFC0_0384, 1'b0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (inst_addr_ok && inst_addr == 32'hBFC0_0008) found = 1;
        end
        check("exc_trigger_seen", found, 1);
        @(negedge clk);
        except_valid = 1'b1;
        @(negedge clk);
        except_valid = 1'b0;
        #1;
        check("exc_valid_d", {31'd0, valid_d}, 32'd0);
        check("exc_fetch_busy", {31'd0, fetch_busy}, 32'd1);
        drain("exception");

        // 6: stall D for 4 cycles while BFC00008 is in D; next fetch is buffered
        do_reset();
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            exp_addr(32'hBFC0_0000 + 32'(4 * i));
            exp_d(32'hBFC0_0000 + 32'(4 * i), 1'b0);
        end
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (valid_d && pc_d == 32'hBFC0_0008) found = 1;
        end
        check("stall_trigger_seen", found, 1);
        stall_d = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("stall_fetch_busy", {31'd0, fetch_busy}, 32'd0);
        check("stall_inst_req", {31'd0, inst_req}, 32'd0);
        check("stall_pc_d", pc_d, 32'hBFC0_0008);
        check("stall_instr_d", instr_d, instr_of(32'hBFC0_0008));
        check("stall_valid_d", {31'd0, valid_d}, 32'd1);
        @(negedge clk);
        stall_d = 1'b0;
        drain("stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
